// File: rtl/addr_trace_gen_pkg.sv
// Shared types and constants for the address trace generator (package trace_pkg).
package trace_pkg;

   localparam logic [1:0] MODE_STRIDE = 2'b00;
   localparam logic [1:0] MODE_LOOP   = 2'b01;
   localparam logic [1:0] MODE_RAND   = 2'b10;
   localparam logic [1:0] MODE_RSVD   = 2'b11;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   // x^31 + x^28 + 1, shifting left with feedback into bit 0
   localparam int unsigned LFSR_W      = 31;
   localparam int unsigned LFSR_TAP_HI = 30;
   localparam int unsigned LFSR_TAP_LO = 27;

   function automatic int unsigned line_off_w(input int unsigned line_size);
      return $clog2(line_size);
   endfunction

endpackage

// File: rtl/addr_trace_gen_if.sv
// Command/address handshake bundle between the trace generator (master) and its consumer.
// gap_41 exists only when TRACE_THROTTLE_EN is defined.
interface addr_trace_gen_if #(
   parameter int unsigned ADDR_W = 31,
   parameter int unsigned CNT_W  = 31
);
   logic              start_41;
   logic [1:0]        mode_41;
   logic [ADDR_W-1:0] base_41;
   logic [ADDR_W-1:0] stride_41;
   logic [ADDR_W-1:0] span_41;
   logic [CNT_W-1:0]  count_41;
   logic              ready_41;
   logic [ADDR_W-1:0] addr_41;
   logic              valid_41;
   logic              busy_41;
   logic              done_41;
   logic [CNT_W-1:0]  issued_41;
`ifdef TRACE_THROTTLE_EN
   logic [7:0]        gap_41;
`endif

   modport master (
      input  start_41, mode_41, base_41, stride_41, span_41, count_41, ready_41,
`ifdef TRACE_THROTTLE_EN
      input  gap_41,
`endif
      output addr_41, valid_41, busy_41, done_41, issued_41
   );

   modport slave (
      output start_41, mode_41, base_41, stride_41, span_41, count_41, ready_41,
`ifdef TRACE_THROTTLE_EN
      output gap_41,
`endif
      input  addr_41, valid_41, busy_41, done_41, issued_41
   );

endinterface

// File: rtl/addr_trace_gen_lfsr.sv
// 31-bit Fibonacci LFSR (x^31 + x^28 + 1) for the random address pattern.
module trace_lfsr
   import trace_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = 31'h1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              en_i,
   output logic [LFSR_W-1:0] state_o
);

   logic [LFSR_W-1:0] state_q, state_d;

   always_comb begin
      state_d = state_q;
      if (en_i) begin
         state_d = {state_q[LFSR_W-2:0], state_q[LFSR_TAP_HI] ^ state_q[LFSR_TAP_LO]};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/addr_trace_gen.sv
// Programmable line-aligned address trace generator (stride / loop / random patterns).
// Define TRACE_THROTTLE_EN to add an inter-transfer gap (gap_41) on the interface.
module addr_trace_gen
   import trace_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 31,
   parameter int unsigned       LINE_SIZE = 8,
   parameter int unsigned       CNT_W     = 31,
   parameter logic [LFSR_W-1:0] LFSR_SEED = 31'h1
) (
   input logic              clk_41,
   input logic              rst_41,
   addr_trace_gen_if.master bus
);

   localparam int unsigned       LSB      = line_off_w(LINE_SIZE);
   localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << LSB) - 64'd1);

   state_e            state_q;
   logic [1:0]        mode_q;
   logic [ADDR_W-1:0] base_q, stride_q, span_q, offset_q, addr_q;
   logic [CNT_W-1:0]  count_q, issued_q;
   logic              valid_q, busy_q, done_q;
`ifdef TRACE_THROTTLE_EN
   logic [7:0]        gap_q, gap_cnt_q;
`endif

   logic [LFSR_W-1:0] lfsr_state;
   logic [ADDR_W-1:0] lfsr_ext, span_eff, rand_mask, offset_d, addr_d;
   logic [ADDR_W:0]   loop_sum;
   logic [CNT_W-1:0]  issued_inc;
   logic              xfer, lfsr_en;

   assign xfer       = (state_q == StRun) && valid_q && bus.ready_41;
   // The LFSR only moves on random-mode transfers so other patterns leave it untouched
   assign lfsr_en    = xfer && (mode_q == MODE_RAND);
   assign issued_inc = issued_q + CNT_W'(1);
   assign lfsr_ext   = ADDR_W'(lfsr_state);

   trace_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk_i   (clk_41),
      .rst_ni  (rst_41),
      .en_i    (lfsr_en),
      .state_o (lfsr_state)
   );

   always_comb begin
      loop_sum  = {1'b0, offset_q} + {1'b0, stride_q};
      span_eff  = (span_q == '0) ? ADDR_W'(1) : span_q;
      rand_mask = (span_q == '0) ? '0 : span_q - ADDR_W'(1);
      case (mode_q)
         MODE_LOOP: offset_d = (loop_sum >= {1'b0, span_eff}) ? '0 : loop_sum[ADDR_W-1:0];
         MODE_RAND: offset_d = lfsr_ext & rand_mask;
         default:   offset_d = offset_q + stride_q;
      endcase
      addr_d = (base_q + (offset_d << LSB)) & ~LOW_MASK;
   end

   always_ff @(posedge clk_41 or negedge rst_41) begin
      if (!rst_41) begin
         state_q   <= StIdle;
         mode_q    <= MODE_STRIDE;
         base_q    <= '0;
         stride_q  <= '0;
         span_q    <= '0;
         count_q   <= '0;
         offset_q  <= '0;
         addr_q    <= '0;
         issued_q  <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef TRACE_THROTTLE_EN
         gap_q     <= '0;
         gap_cnt_q <= '0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.start_41) begin
                  mode_q   <= bus.mode_41;
                  base_q   <= bus.base_41;
                  stride_q <= bus.stride_41;
                  span_q   <= bus.span_41;
                  count_q  <= bus.count_41;
                  offset_q <= '0;
                  issued_q <= '0;
                  addr_q   <= bus.base_41 & ~LOW_MASK;
                  busy_q   <= 1'b1;
`ifdef TRACE_THROTTLE_EN
                  gap_q     <= bus.gap_41;
                  gap_cnt_q <= '0;
`endif
                  if ((bus.count_41 == '0) || (bus.mode_41 == MODE_RSVD)) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= StRun;
                     valid_q <= 1'b1;
                  end
               end
            end
            StRun: begin
               if (xfer) begin
                  issued_q <= issued_inc;
                  if (issued_inc == count_q) begin
                     state_q <= StDone;
                     valid_q <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     offset_q <= offset_d;
                     addr_q   <= addr_d;
`ifdef TRACE_THROTTLE_EN
                     if (gap_q != '0) begin
                        valid_q   <= 1'b0;
                        gap_cnt_q <= gap_q;
                     end
`endif
                  end
               end
`ifdef TRACE_THROTTLE_EN
               else if (!valid_q) begin
                  if (gap_cnt_q == 8'd1) valid_q <= 1'b1;
                  gap_cnt_q <= gap_cnt_q - 8'd1;
               end
`endif
            end
            StDone: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.addr_41   = addr_q;
   assign bus.valid_41  = valid_q;
   assign bus.busy_41   = busy_q;
   assign bus.done_41   = done_q;
   assign bus.issued_41 = issued_q;

endmodule

// File: tb/tb_addr_trace_gen.sv
// Self-checking bench for addr_trace_gen: directed table, hand sequences, randomized runs
// against a behavioural model of the address patterns.
module tb_addr_trace_gen;

   localparam int unsigned   ADDR_W = 31;
   localparam int unsigned   CNT_W  = 31;
   localparam longint        LINE   = 8;
   localparam longint        MODV   = 64'd1 << 31;
   localparam logic [30:0]   SEED   = 31'h1;
   localparam int            BUDGET = 3000;

   logic clk;
   logic rst_41;

   addr_trace_gen_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

   addr_trace_gen #(
      .ADDR_W    (ADDR_W),
      .LINE_SIZE (8),
      .CNT_W     (CNT_W),
      .LFSR_SEED (SEED)
   ) dut (
      .clk_41 (clk),
      .rst_41 (rst_41),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          chk_cnt = 0;
   int          err_cnt = 0;
   longint      m_lfsr;
   logic [30:0] exp_q[$];

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic longint lfsr_step(input longint s);
      longint fb;
      fb = ((s >> 30) ^ (s >> 27)) & 1;
      return ((s << 1) | fb) % MODV;
   endfunction

   // Expected address list straight from the pattern rules
   function automatic void build_exp(input logic [1:0] mode, input logic [30:0] base,
                                     input logic [30:0] stride, input logic [30:0] span,
                                     input logic [30:0] count);
      longint b, st, sp, off;
      b  = longint'(base);
      st = longint'(stride);
      sp = longint'(span);
      off = 0;
      exp_q.delete();
      if (mode == 2'b11) return;
      for (longint i = 0; i < longint'(count); i++) begin
         exp_q.push_back(31'(((b + off * LINE) % MODV) / LINE * LINE));
         case (mode)
            2'b00: off = (off + st) % MODV;
            2'b01: begin
               if (off + st >= ((sp == 0) ? 1 : sp)) off = 0;
               else off = off + st;
            end
            default: begin
               off    = (sp == 0) ? 0 : (m_lfsr % sp);
               m_lfsr = lfsr_step(m_lfsr);
            end
         endcase
      end
   endfunction

   task automatic do_run(input logic [1:0] mode, input logic [30:0] base,
                         input logic [30:0] stride, input logic [30:0] span,
                         input logic [30:0] count, input int ready_pct, input int stall_at,
                         input logic [7:0] gap, input string name,
                         output logic [30:0] first_a, output logic [30:0] last_a);
      int          k, i, exp_n, gap_eff, stall_cnt, done_idx;
      int          xfer_idx[$];
      logic        prev_stall, done_seen, rdy;
      logic [30:0] prev_addr;
      build_exp(mode, base, stride, span, count);
      exp_n   = exp_q.size();
      gap_eff = 0;
`ifdef TRACE_THROTTLE_EN
      gap_eff    = int'(gap);
      bus.gap_41 = gap;
`endif
      bus.mode_41   = mode;
      bus.base_41   = base;
      bus.stride_41 = stride;
      bus.span_41   = span;
      bus.count_41  = count;
      bus.start_41  = 1'b1;
      bus.ready_41  = 1'b1;
      @(negedge clk);
      // Scramble inputs during the run; the DUT must use the latched copies
      bus.start_41  = 1'b0;
      bus.mode_41   = 2'($urandom);
      bus.base_41   = 31'($urandom);
      bus.stride_41 = 31'($urandom);
      bus.span_41   = 31'($urandom);
      bus.count_41  = 31'($urandom);
`ifdef TRACE_THROTTLE_EN
      bus.gap_41    = 8'($urandom);
`endif
      k = 0; i = 1; prev_stall = 1'b0; done_seen = 1'b0; stall_cnt = 0; done_idx = 0;
      first_a = '0; last_a = '0; prev_addr = '0;
      while (!done_seen && i <= BUDGET) begin
         if (bus.done_41) begin
            done_seen = 1'b1;
            done_idx  = i;
            check({name, " done_valid"}, 64'(bus.valid_41), 64'd0);
            check({name, " done_busy"}, 64'(bus.busy_41), 64'd1);
            check({name, " final_issued"}, 64'(bus.issued_41), 64'(exp_n));
            check({name, " xfer_count"}, 64'(k), 64'(exp_n));
            bus.start_41 = 1'b1;
            bus.mode_41  = 2'b00;
            bus.count_41 = 31'd5;
         end else begin
            check({name, " busy"}, 64'(bus.busy_41), 64'd1);
            check({name, " issued"}, 64'(bus.issued_41), 64'(k));
            if (prev_stall) begin
               check({name, " hold_valid"}, 64'(bus.valid_41), 64'd1);
               check({name, " hold_addr"}, 64'(bus.addr_41), 64'(prev_addr));
            end
            if (bus.valid_41 && k == stall_at && stall_cnt < 3) begin
               rdy = 1'b0;
               stall_cnt++;
            end else begin
               rdy = ($urandom_range(99) < ready_pct);
            end
            if (bus.valid_41 && rdy) begin
               if (k < exp_n) check({name, " addr"}, 64'(bus.addr_41), 64'(exp_q[k]));
               else check({name, " extra_xfer"}, 64'(k), 64'(exp_n));
               if (k == 0) first_a = bus.addr_41;
               last_a = bus.addr_41;
               xfer_idx.push_back(i);
               k++;
            end
            prev_stall   = bus.valid_41 && !rdy;
            prev_addr    = bus.addr_41;
            bus.ready_41 = rdy;
            @(negedge clk);
            i++;
         end
      end
      if (!done_seen) begin
         check({name, " done_timeout"}, 64'd0, 64'd1);
      end else begin
         if (ready_pct == 100 && stall_at < 0) begin
            foreach (xfer_idx[j]) begin
               check({name, " xfer_cycle"}, 64'(xfer_idx[j]), 64'(1 + j * (gap_eff + 1)));
            end
            check({name, " done_cycle"}, 64'(done_idx),
                  64'((exp_n == 0) ? 1 : 2 + (exp_n - 1) * (gap_eff + 1)));
         end
         // A start presented while done was high must have been ignored
         @(negedge clk);
         bus.start_41 = 1'b0;
         check({name, " post_done"}, 64'(bus.done_41), 64'd0);
         check({name, " post_busy"}, 64'(bus.busy_41), 64'd0);
         check({name, " post_valid"}, 64'(bus.valid_41), 64'd0);
         check({name, " post_issued"}, 64'(bus.issued_41), 64'(exp_n));
      end
   endtask

   typedef struct {
      logic [1:0]  mode;
      logic [30:0] base;
      logic [30:0] stride;
      logic [30:0] span;
      logic [30:0] count;
      int          stall_at;
      logic [30:0] exp_first;
      logic [30:0] exp_last;
      string       name;
   } vec_t;

   vec_t vecs[9];

   initial begin
      logic [30:0] fa, la, rb, rs, rp, rc;
      logic [1:0]  rm;
      logic [7:0]  rg;
      int          rpct;

      vecs[0] = '{2'd0, 31'h100, 31'd1, 31'd0, 31'd4, -1, 31'h100, 31'h118, "stride_seq"};
      vecs[1] = '{2'd1, 31'h0, 31'd1, 31'd3, 31'd7, -1, 31'h0, 31'h0, "loop_seq"};
      vecs[2] = '{2'd0, 31'h100, 31'd1, 31'd0, 31'd6, 1, 31'h100, 31'h128, "backpressure"};
      vecs[3] = '{2'd0, 31'h7FFFFFF8, 31'd1, 31'd0, 31'd2, -1, 31'h7FFFFFF8, 31'h0, "wrap"};
      vecs[4] = '{2'd0, 31'h40, 31'd1, 31'd0, 31'd0, -1, 31'h0, 31'h0, "count_zero"};
      vecs[5] = '{2'd1, 31'h40, 31'd3, 31'd0, 31'd3, -1, 31'h40, 31'h40, "loop_span0"};
      vecs[6] = '{2'd0, 31'h105, 31'd2, 31'd0, 31'd3, -1, 31'h100, 31'h120, "unaligned"};
      vecs[7] = '{2'd1, 31'h1000, 31'd2, 31'd5, 31'd5, -1, 31'h1000, 31'h1010, "loop_wrap"};
      vecs[8] = '{2'd3, 31'h80, 31'd1, 31'd4, 31'd5, -1, 31'h0, 31'h0, "reserved"};

      rst_41 = 1'b0;
      bus.start_41 = 1'b0; bus.mode_41 = '0; bus.base_41 = '0; bus.stride_41 = '0;
      bus.span_41 = '0; bus.count_41 = '0; bus.ready_41 = 1'b0;
`ifdef TRACE_THROTTLE_EN
      bus.gap_41 = '0;
`endif
      m_lfsr = longint'(SEED);
      repeat (2) @(negedge clk);
      check("rst_addr", 64'(bus.addr_41), 64'd0);
      check("rst_valid", 64'(bus.valid_41), 64'd0);
      check("rst_busy", 64'(bus.busy_41), 64'd0);
      check("rst_done", 64'(bus.done_41), 64'd0);
      check("rst_issued", 64'(bus.issued_41), 64'd0);
      rst_41 = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 9; v++) begin
         do_run(vecs[v].mode, vecs[v].base, vecs[v].stride, vecs[v].span, vecs[v].count, 100,
                vecs[v].stall_at, 8'd0, vecs[v].name, fa, la);
         if (vecs[v].count != 0 && vecs[v].mode != 2'd3) begin
            check({vecs[v].name, " first"}, 64'(fa), 64'(vecs[v].exp_first));
            check({vecs[v].name, " last"}, 64'(la), 64'(vecs[v].exp_last));
         end
      end

`ifdef TRACE_THROTTLE_EN
      do_run(2'd0, 31'h200, 31'd1, 31'd0, 31'd3, 100, -1, 8'd2, "throttle", fa, la);
`endif

      // Reset in the middle of a random run: outputs drop at once, LFSR reseeds
      bus.mode_41 = 2'd2; bus.base_41 = 31'h3000; bus.stride_41 = '0;
      bus.span_41 = 31'd16; bus.count_41 = 31'd20; bus.ready_41 = 1'b1;
      bus.start_41 = 1'b1;
      @(negedge clk);
      bus.start_41 = 1'b0;
      repeat (5) @(negedge clk);
      check("midrun_valid", 64'(bus.valid_41), 64'd1);
      rst_41 = 1'b0;
      #1;
      check("midrst_valid", 64'(bus.valid_41), 64'd0);
      check("midrst_busy", 64'(bus.busy_41), 64'd0);
      check("midrst_done", 64'(bus.done_41), 64'd0);
      check("midrst_issued", 64'(bus.issued_41), 64'd0);
      check("midrst_addr", 64'(bus.addr_41), 64'd0);
      @(negedge clk);
      check("midrst_no_done", 64'(bus.done_41), 64'd0);
      rst_41 = 1'b1;
      m_lfsr = longint'(SEED);
      @(negedge clk);
      do_run(2'd2, 31'h2000, 31'd0, 31'd16, 31'd20, 100, -1, 8'd0, "random16", fa, la);

      for (int r = 0; r < 14; r++) begin
         rm = 2'($urandom_range(0, 3));
         rb = 31'($urandom);
         rs = ($urandom_range(0, 1) == 0) ? 31'($urandom_range(0, 4)) : 31'($urandom);
         if (rm == 2'd2) rp = ($urandom_range(0, 5) == 0) ? 31'd0 : 31'(1 << $urandom_range(0, 6));
         else rp = 31'($urandom_range(0, 9));
         rc   = 31'($urandom_range(0, 12));
         rpct = int'($urandom_range(40, 100));
         rg   = 8'($urandom_range(0, 3));
         do_run(rm, rb, rs, rp, rc, rpct, -1, rg, "rand_run", fa, la);
      end

      $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

endmodule
